planificador_necesidades: RTL and testbench

Need scheduler for the Tamagotchi core. Keeps three need levels (hambre, energia, animo) and ages them on a shared one-second tick. Applies feed/play/sleep button actions with fixed-priority arbitration. Sequences the primitive-mode level counter by issuing single-cycle `Entrada_Sube_Nivel` pulses while the pet is well cared for.

---
 rtl/tamagotchi_pkg.sv | 38 +++
 rtl/prescaler_tick.sv | 40 ++++
 rtl/planificador_necesidades.sv | 206 ++++++++++++++++++++
 tb/tb_planificador_necesidades.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the Tamagotchi core: state encoding, level limits,
// button effects and the level clamp helper.
package tamagotchi_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DORMIR = 2'd1,
    ST_MUERTO = 2'd2
  } estado_t;

  typedef struct packed {
    logic alimentar;
    logic jugar;
    logic dormir;
  } botones_t;

  localparam int NIVEL_MAX           = 7;
  localparam int NIVEL_RESET         = 5;
  localparam int UMBRAL_BIEN         = 4;
  localparam int BONO_ALIMENTAR      = 2;
  localparam int BONO_JUGAR_ANIMO    = 2;
  localparam int COSTE_JUGAR_ENERGIA = 1;

  function automatic int ancho_cnt(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Levels are combined in 5-bit signed arithmetic, then saturated to 0..7.
  function automatic logic [2:0] nivel_sat(input logic signed [4:0] v);
    if (v < 5'sd0)
      return 3'd0;
    else if (v > 5'(NIVEL_MAX))
      return 3'(NIVEL_MAX);
    else
      return v[2:0];
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Tick generator: one-cycle pulse every TICK_DIV clocks, or every TEST_DIV
// clocks while test mode is selected. A mode change restarts the phase.
module prescaler_tick
  import tamagotchi_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int TEST_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_test,
  output logic o_tick
);

  localparam int MAX_DIV = (TICK_DIV > TEST_DIV) ? TICK_DIV : TEST_DIV;
  localparam int CW      = ancho_cnt(MAX_DIV);

  logic [CW-1:0] r_cnt;
  logic          r_test_q;
  logic [CW-1:0] w_div_m1;
  logic          w_test_chg;

  assign w_div_m1   = i_test ? CW'(TEST_DIV - 1) : CW'(TICK_DIV - 1);
  assign w_test_chg = i_test ^ r_test_q;
  assign o_tick     = ~w_test_chg & (r_cnt == w_div_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_test_q <= 1'b0;
    end else begin
      r_test_q <= i_test;
      if (w_test_chg || o_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/planificador_necesidades.sv
// Need scheduler: ages hambre/energia/animo on the shared tick, applies
// arbitrated button actions and emits level-up pulses while the pet is well.
module planificador_necesidades
  import tamagotchi_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int TEST_DIV      = 4,
  parameter int DECAY_HAMBRE  = 5,
  parameter int DECAY_ENERGIA = 8,
  parameter int DECAY_ANIMO   = 6,
  parameter int GROW_TICKS    = 10
) (
  input  logic       clk,
  input  logic       B_reset,
  input  logic       B_test,
  input  logic       B_alimentar,
  input  logic       B_jugar,
  input  logic       B_dormir,
  output logic       Entrada_Sube_Nivel,
  output logic [2:0] Nivel_hambre,
  output logic [2:0] Nivel_energia,
  output logic [2:0] Nivel_animo,
  output logic [1:0] Estado
);

  // state  | meaning
  // NORMAL | awake: buttons act, all three needs decay
  // DORMIR | asleep: energia +1 per tick, feed/play ignored
  // MUERTO | absorbing: everything frozen until B_reset

  localparam int HW = ancho_cnt(DECAY_HAMBRE);
  localparam int EW = ancho_cnt(DECAY_ENERGIA);
  localparam int AW = ancho_cnt(DECAY_ANIMO);
  localparam int GW = ancho_cnt(GROW_TICKS);

  estado_t         r_estado, w_estado_sig;
  botones_t        r_prev, w_flanco, w_accion;
  logic [2:0]      r_hambre, r_energia, r_animo;
  logic [2:0]      w_hambre_nuevo, w_energia_nuevo, w_animo_nuevo;
  logic signed [4:0] w_hambre_suma, w_energia_suma, w_animo_suma;
  logic [HW-1:0]   r_cnt_hambre;
  logic [EW-1:0]   r_cnt_energia;
  logic [AW-1:0]   r_cnt_animo;
  logic [GW-1:0]   r_grow_cnt;
  logic            r_pulso;
  logic            w_tick;
  logic            w_en_hambre_animo, w_en_energia, w_acepta_botones, w_recarga;
  logic            w_req_hambre, w_req_energia, w_req_animo;
  logic            w_muere, w_bien, w_grow_fin;

  prescaler_tick #(
    .TICK_DIV (TICK_DIV),
    .TEST_DIV (TEST_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (B_reset),
    .i_test (B_test),
    .o_tick (w_tick)
  );

  // Edge detect, then fixed priority alimentar > jugar > dormir.
  assign w_flanco = botones_t'({B_alimentar, B_jugar, B_dormir}) & ~r_prev;

  always_comb begin
    w_accion           = '0;
    w_accion.alimentar = w_flanco.alimentar;
    w_accion.jugar     = w_flanco.jugar & ~w_flanco.alimentar;
    w_accion.dormir    = w_flanco.dormir & ~w_flanco.jugar & ~w_flanco.alimentar;
  end

  always_ff @(posedge clk or negedge B_reset) begin
    if (!B_reset)
      r_prev <= '0;
    else
      r_prev <= botones_t'({B_alimentar, B_jugar, B_dormir});
  end

  always_ff @(posedge clk or negedge B_reset) begin
    if (!B_reset)
      r_estado <= ST_NORMAL;
    else
      r_estado <= w_estado_sig;
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      ST_NORMAL: begin
        if (w_muere)
          w_estado_sig = ST_MUERTO;
        else if (w_accion.dormir)
          w_estado_sig = ST_DORMIR;
      end
      ST_DORMIR: begin
        if (w_muere)
          w_estado_sig = ST_MUERTO;
        else if (w_accion.dormir || (w_energia_nuevo == 3'(NIVEL_MAX)))
          w_estado_sig = ST_NORMAL;
      end
      default: w_estado_sig = ST_MUERTO;
    endcase
  end

  always_comb begin
    w_en_hambre_animo = 1'b0;
    w_en_energia      = 1'b0;
    w_acepta_botones  = 1'b0;
    w_recarga         = 1'b0;
    case (r_estado)
      ST_NORMAL: begin
        w_en_hambre_animo = 1'b1;
        w_en_energia      = 1'b1;
        w_acepta_botones  = 1'b1;
      end
      ST_DORMIR: begin
        w_en_hambre_animo = 1'b1;
        w_recarga         = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_req_hambre  = w_tick & w_en_hambre_animo & (r_cnt_hambre  == HW'(DECAY_HAMBRE - 1));
  assign w_req_animo   = w_tick & w_en_hambre_animo & (r_cnt_animo   == AW'(DECAY_ANIMO - 1));
  assign w_req_energia = w_tick & w_en_energia      & (r_cnt_energia == EW'(DECAY_ENERGIA - 1));

  always_ff @(posedge clk or negedge B_reset) begin
    if (!B_reset) begin
      r_cnt_hambre  <= '0;
      r_cnt_energia <= '0;
      r_cnt_animo   <= '0;
    end else begin
      if (w_tick && w_en_hambre_animo) begin
        r_cnt_hambre <= w_req_hambre ? '0 : r_cnt_hambre + 1'b1;
        r_cnt_animo  <= w_req_animo  ? '0 : r_cnt_animo + 1'b1;
      end
      if (w_tick && w_en_energia)
        r_cnt_energia <= w_req_energia ? '0 : r_cnt_energia + 1'b1;
    end
  end

  // Decay and button effects fold into one saturated update per cycle.
  always_comb begin
    w_hambre_suma  = $signed({2'b00, r_hambre});
    w_energia_suma = $signed({2'b00, r_energia});
    w_animo_suma   = $signed({2'b00, r_animo});
    if (w_req_hambre)
      w_hambre_suma = w_hambre_suma - 5'sd1;
    if (w_req_energia)
      w_energia_suma = w_energia_suma - 5'sd1;
    if (w_req_animo)
      w_animo_suma = w_animo_suma - 5'sd1;
    if (w_acepta_botones && w_accion.alimentar)
      w_hambre_suma = w_hambre_suma + 5'(BONO_ALIMENTAR);
    if (w_acepta_botones && w_accion.jugar) begin
      w_animo_suma   = w_animo_suma + 5'(BONO_JUGAR_ANIMO);
      w_energia_suma = w_energia_suma - 5'(COSTE_JUGAR_ENERGIA);
    end
    if (w_recarga && w_tick)
      w_energia_suma = w_energia_suma + 5'sd1;
  end

  assign w_hambre_nuevo  = nivel_sat(w_hambre_suma);
  assign w_energia_nuevo = nivel_sat(w_energia_suma);
  assign w_animo_nuevo   = nivel_sat(w_animo_suma);
  assign w_muere         = (w_hambre_nuevo == 3'd0) && (w_energia_nuevo == 3'd0);

  always_ff @(posedge clk or negedge B_reset) begin
    if (!B_reset) begin
      r_hambre  <= 3'(NIVEL_RESET);
      r_energia <= 3'(NIVEL_RESET);
      r_animo   <= 3'(NIVEL_RESET);
    end else if (r_estado != ST_MUERTO) begin
      r_hambre  <= w_hambre_nuevo;
      r_energia <= w_energia_nuevo;
      r_animo   <= w_animo_nuevo;
    end
  end

  assign w_bien = (r_estado == ST_NORMAL) &&
                  (r_hambre  >= 3'(UMBRAL_BIEN)) &&
                  (r_energia >= 3'(UMBRAL_BIEN)) &&
                  (r_animo   >= 3'(UMBRAL_BIEN));
  assign w_grow_fin = w_bien && w_tick && (r_grow_cnt == GW'(GROW_TICKS - 1));

  always_ff @(posedge clk or negedge B_reset) begin
    if (!B_reset) begin
      r_grow_cnt <= '0;
      r_pulso    <= 1'b0;
    end else begin
      if (!w_bien)
        r_grow_cnt <= '0;
      else if (w_tick)
        r_grow_cnt <= w_grow_fin ? '0 : r_grow_cnt + 1'b1;
      // Suppressed if a same-cycle action takes the pet out of NORMAL.
      r_pulso <= w_grow_fin && (w_estado_sig == ST_NORMAL);
    end
  end

  assign Entrada_Sube_Nivel = r_pulso;
  assign Nivel_hambre       = r_hambre;
  assign Nivel_energia      = r_energia;
  assign Nivel_animo        = r_animo;
  assign Estado             = r_estado;

endmodule

// File: tb/tb_planificador_necesidades.sv
// Directed bench for planificador_necesidades with TICK_DIV=8, TEST_DIV=2;
// expected levels are hand-derived cycle counts from reset release.
`timescale 1ns/1ps
module tb_planificador_necesidades;

  logic       clk = 1'b0;
  logic       B_reset, B_test, B_alimentar, B_jugar, B_dormir;
  logic       Entrada_Sube_Nivel;
  logic [2:0] Nivel_hambre, Nivel_energia, Nivel_animo;
  logic [1:0] Estado;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int pulse_hi = 0;
  int pulse_rise = 0;
  logic pulse_prev = 1'b0;

  planificador_necesidades #(
    .TICK_DIV      (8),
    .TEST_DIV      (2),
    .DECAY_HAMBRE  (5),
    .DECAY_ENERGIA (8),
    .DECAY_ANIMO   (6),
    .GROW_TICKS    (10)
  ) dut (
    .clk                (clk),
    .B_reset            (B_reset),
    .B_test             (B_test),
    .B_alimentar        (B_alimentar),
    .B_jugar            (B_jugar),
    .B_dormir           (B_dormir),
    .Entrada_Sube_Nivel (Entrada_Sube_Nivel),
    .Nivel_hambre       (Nivel_hambre),
    .Nivel_energia      (Nivel_energia),
    .Nivel_animo        (Nivel_animo),
    .Estado             (Estado)
  );

  always #5 clk = ~clk;

  // Posedges since the last reset release.
  always @(posedge clk or negedge B_reset) begin
    if (!B_reset) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    pulse_prev <= Entrada_Sube_Nivel;
    if (Entrada_Sube_Nivel) pulse_hi <= pulse_hi + 1;
    if (Entrada_Sube_Nivel && !pulse_prev) pulse_rise <= pulse_rise + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_levels(input string tag, input int h, input int e, input int a, input int st);
    check({tag, ".hambre"},  32'(Nivel_hambre),  32'(h));
    check({tag, ".energia"}, 32'(Nivel_energia), 32'(e));
    check({tag, ".animo"},   32'(Nivel_animo),   32'(a));
    check({tag, ".estado"},  32'(Estado),        32'(st));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    B_reset = 1'b0; B_test = 1'b0;
    B_alimentar = 1'b0; B_jugar = 1'b0; B_dormir = 1'b0;
    #23;
    check_levels("reset", 5, 5, 5, 0);
    check("reset.pulse", 32'(Entrada_Sube_Nivel), 0);
    @(negedge clk); B_reset = 1'b1;

    // Idle ticks: tick k lands on posedge 8k.
    wait_cyc(39);  check_levels("idle_p39", 5, 5, 5, 0);
    wait_cyc(40);  check_levels("idle_5ticks", 4, 5, 5, 0);
    check("idle.pulses", 32'(pulse_hi), 0);

    // Coincident feed + play: play is dropped.
    B_alimentar = 1'b1; B_jugar = 1'b1;
    wait_cyc(41);  check_levels("feed_play", 6, 5, 5, 0);
    B_alimentar = 1'b0; B_jugar = 1'b0; B_dormir = 1'b1;
    wait_cyc(42);  check("sleep.enter", 32'(Estado), 1);
    B_dormir = 1'b0;
    wait_cyc(48);  check_levels("sleep_tick1", 6, 6, 4, 1);
    B_alimentar = 1'b1;
    wait_cyc(50);  check("sleep.feed_ignored", 32'(Nivel_hambre), 6);
    B_alimentar = 1'b0;
    wait_cyc(55);  check_levels("sleep_p55", 6, 6, 4, 1);
    wait_cyc(56);  check_levels("sleep_exit_e7", 6, 7, 4, 0);

    // Growth: well ticks 8..17, kept up with one play and one feed.
    wait_cyc(89);  B_jugar = 1'b1;
    wait_cyc(90);  check_levels("grow_play", 5, 5, 6, 0);
    B_jugar = 1'b0;
    wait_cyc(120); check("grow.h_decay", 32'(Nivel_hambre), 4);
    B_alimentar = 1'b1;
    wait_cyc(121); check("grow.feed", 32'(Nivel_hambre), 6);
    B_alimentar = 1'b0;
    wait_cyc(135); check("grow.no_early_pulse", 32'(pulse_hi), 0);
    wait_cyc(136); check("grow.pulse_high", 32'(Entrada_Sube_Nivel), 1);
    wait_cyc(137); check("grow.pulse_low", 32'(Entrada_Sube_Nivel), 0);
    check("grow.pulse_width", 32'(pulse_hi), 1);
    check("grow.pulse_count", 32'(pulse_rise), 1);

    // Animo falls to 3 on tick 24, seven ticks into the next count.
    wait_cyc(192); check_levels("animo_drop", 5, 4, 3, 0);
    wait_cyc(216); check("nowell.no_pulse", 32'(pulse_hi), 1);

    // Starvation: hambre 0 at tick 45, energia 0 at tick 50.
    wait_cyc(399); check_levels("pre_death", 0, 1, 0, 0);
    wait_cyc(400); check_levels("death", 0, 0, 0, 2);
    wait_cyc(401); B_alimentar = 1'b1;
    wait_cyc(403); B_alimentar = 1'b0;
    wait_cyc(404); B_jugar = 1'b1;
    wait_cyc(406); B_jugar = 1'b0;
    wait_cyc(407); B_dormir = 1'b1;
    wait_cyc(409); B_dormir = 1'b0;
    wait_cyc(440); check_levels("dead_frozen", 0, 0, 0, 2);
    check("dead.no_pulse", 32'(pulse_hi), 1);
    B_reset = 1'b0;
    #1;
    check_levels("dead_reset", 5, 5, 5, 0);
    #20;
    @(negedge clk); B_reset = 1'b1;

    // Two plays (animo clamps at 7), sleep, then async reset mid-cycle.
    wait_cyc(1);   B_jugar = 1'b1;
    wait_cyc(2);   check_levels("play1", 5, 4, 7, 0);
    B_jugar = 1'b0;
    wait_cyc(3);   B_jugar = 1'b1;
    wait_cyc(4);   check_levels("play2_clamp", 5, 3, 7, 0);
    B_jugar = 1'b0;
    wait_cyc(5);   B_dormir = 1'b1;
    wait_cyc(6);   check_levels("sleep2", 5, 3, 7, 1);
    B_dormir = 1'b0;
    #2;
    B_reset = 1'b0;
    #1;
    check_levels("async_reset", 5, 5, 5, 0);
    check("async_reset.pulse", 32'(Entrada_Sube_Nivel), 0);

    // Test mode from reset: first cycle clears the phase, ticks every 2.
    B_test = 1'b1;
    #15;
    @(negedge clk); B_reset = 1'b1;
    wait_cyc(10);  check_levels("test_p10", 5, 5, 5, 0);
    wait_cyc(11);  check_levels("test_5ticks", 4, 5, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
